// File: rtl/inst_axi_rd_bridge_pkg.sv
// Shared AXI read-side constants, fetch size encodings and AR FSM state type.
package axi_defs;

   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [7:0] LEN_SINGLE  = 8'd0;
   localparam logic [3:0] CACHE_NONE  = 4'd0;
   localparam logic [2:0] PROT_NONE   = 3'd0;
   localparam logic [1:0] LOCK_NORMAL = 2'd0;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   typedef logic [0:0] ar_state_t;
   localparam ar_state_t AR_IDLE = 1'b0;
   localparam ar_state_t AR_SEND = 1'b1;

endpackage

// File: rtl/inst_axi_rd_bridge.sv
// Fetch-side SRAM-like request port to AXI4 read master; in-order, single ID.
module inst_axi_rd_bridge
   import axi_defs::*;
#(
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter logic [3:0]  ARID_VAL        = 4'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        inst_sram_req,
   input  logic        inst_sram_wr,
   input  logic [1:0]  inst_sram_size,
   input  logic [31:0] inst_sram_addr,
   output logic        inst_sram_addr_ok,
   output logic        inst_sram_data_ok,
   output logic [31:0] inst_sram_rdata,
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic [1:0]  arlock,
   output logic [3:0]  arcache,
   output logic [2:0]  arprot,
   output logic        arvalid,
   input  logic        arready,
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready
);

   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

   ar_state_t          state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [31:0]        araddr_q;
   logic [2:0]         arsize_q;
   logic               rready_q;
   logic               data_ok_q;
   logic [31:0]        rdata_q;
   logic               addr_ok_c;
   logic               r_hs_c;

   // Write flag, ID, response and last are deliberately not consumed.
   wire unused_inputs = &{1'b0, inst_sram_wr, rid, rresp, rlast};

   assign r_hs_c = rvalid & rready_q;

   // AR FSM next state; address is only accepted while idle and below the limit.
   always_comb begin
      state_d   = state_q;
      addr_ok_c = 1'b0;
      case (state_q)
         AR_IDLE: begin
            addr_ok_c = inst_sram_req & (cnt_q < CNT_W'(MAX_OUTSTANDING));
            if (addr_ok_c) state_d = AR_SEND;
         end
         AR_SEND: begin
            if (arready) state_d = AR_IDLE;
         end
         default: state_d = AR_IDLE;
      endcase
   end

   // Outstanding count: accept increments, R handshake decrements, both cancel.
   always_comb begin
      cnt_d = cnt_q;
      case ({addr_ok_c, r_hs_c})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // State, AR payload latch and registered return path.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= AR_IDLE;
         cnt_q     <= '0;
         araddr_q  <= '0;
         arsize_q  <= '0;
         rready_q  <= 1'b0;
         data_ok_q <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rready_q  <= (cnt_d != '0);
         data_ok_q <= r_hs_c;
         if (addr_ok_c) begin
            araddr_q <= inst_sram_addr;
            arsize_q <= {1'b0, inst_sram_size};
         end
         if (r_hs_c) rdata_q <= rdata;
      end
   end

   assign inst_sram_addr_ok = addr_ok_c;
   assign inst_sram_data_ok = data_ok_q;
   assign inst_sram_rdata   = rdata_q;

   assign arid    = ARID_VAL;
   assign araddr  = araddr_q;
   assign arlen   = LEN_SINGLE;
   assign arsize  = arsize_q;
   assign arburst = BURST_INCR;
   assign arlock  = LOCK_NORMAL;
   assign arcache = CACHE_NONE;
   assign arprot  = PROT_NONE;
   assign arvalid = (state_q == AR_SEND);
   assign rready  = rready_q;

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Directed bench for the instruction read bridge with an R-data scoreboard.
module tb_inst_axi_rd_bridge;
   import axi_defs::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        inst_sram_req;
   logic        inst_sram_wr;
   logic [1:0]  inst_sram_size;
   logic [31:0] inst_sram_addr;
   logic        inst_sram_addr_ok;
   logic        inst_sram_data_ok;
   logic [31:0] inst_sram_rdata;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [1:0]  arlock;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   int vectors     = 0;
   int miscompares = 0;
   logic [31:0] exp_q[$];

   inst_axi_rd_bridge #(.MAX_OUTSTANDING(2), .ARID_VAL(4'h0)) dut (
      .clk(clk), .reset(reset),
      .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
      .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
      .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
      .inst_sram_rdata(inst_sram_rdata),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
      .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
      .rvalid(rvalid), .rready(rready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   // Scoreboard: accepted R beats are expected back on data_ok in order.
   always @(negedge clk) begin
      if (reset) begin
         exp_q.delete();
      end else begin
         if (inst_sram_data_ok) begin
            if (exp_q.size() == 0) check("sb_unexpected_data_ok", 32'd1, 32'd0);
            else check("sb_rdata", inst_sram_rdata, exp_q.pop_front());
         end
         if (rvalid && rready) exp_q.push_back(rdata);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   // Complete fetch: accept, AR with immediate arready, R three cycles later.
   task automatic single_fetch(input logic [31:0] a, input logic [31:0] d, input string tg);
      int pulses;
      pulses = 0;
      inst_sram_req = 1'b1; inst_sram_addr = a; inst_sram_size = SIZE_WORD;
      settle();
      if (inst_sram_addr_ok) pulses++;
      tick();
      inst_sram_req = 1'b0;
      settle();
      if (inst_sram_addr_ok) pulses++;
      check({tg, "_arvalid"}, 32'(arvalid), 32'd1);
      check({tg, "_araddr"}, araddr, a);
      check({tg, "_arsize"}, 32'(arsize), 32'd2);
      check({tg, "_arlen"}, 32'(arlen), 32'd0);
      check({tg, "_arburst"}, 32'(arburst), 32'd1);
      arready = 1'b1;
      tick();
      arready = 1'b0;
      settle();
      check({tg, "_arvalid_drop"}, 32'(arvalid), 32'd0);
      check({tg, "_addr_ok_pulses"}, 32'(pulses), 32'd1);
      tick();
      tick();
      rvalid = 1'b1; rdata = d;
      settle();
      check({tg, "_rready"}, 32'(rready), 32'd1);
      tick();
      rvalid = 1'b0; rdata = 32'h0;
      settle();
      check({tg, "_data_ok"}, 32'(inst_sram_data_ok), 32'd1);
      check({tg, "_rdata"}, inst_sram_rdata, d);
      check({tg, "_cnt_zero"}, 32'(rready), 32'd0);
      tick();
      check({tg, "_data_ok_pulse"}, 32'(inst_sram_data_ok), 32'd0);
   endtask

   initial begin
      int pulses;
      reset = 1'b1; inst_sram_req = 1'b0; inst_sram_wr = 1'b0;
      inst_sram_size = 2'd0; inst_sram_addr = 32'h0;
      arready = 1'b0; rid = 4'h0; rdata = 32'h0; rresp = 2'b00; rlast = 1'b1; rvalid = 1'b0;
      repeat (3) tick();
      check("rst_arvalid", 32'(arvalid), 32'd0);
      check("rst_araddr", araddr, 32'd0);
      check("rst_arsize", 32'(arsize), 32'd0);
      check("rst_rready", 32'(rready), 32'd0);
      check("rst_data_ok", 32'(inst_sram_data_ok), 32'd0);
      check("rst_rdata", inst_sram_rdata, 32'd0);
      reset = 1'b0;
      tick();

      // 1: single fetch
      single_fetch(32'h1C00_0000, 32'h0280_0404, "s1");

      // 2: outstanding limit with req held, rvalid off
      inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0100; inst_sram_size = SIZE_WORD;
      inst_sram_wr = 1'b1;
      arready = 1'b1;
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         settle();
         if (inst_sram_addr_ok) pulses++;
         tick();
      end
      settle();
      check("s2_pulses", 32'(pulses), 32'd2);
      check("s2_blocked", 32'(inst_sram_addr_ok), 32'd0);
      check("s2_arvalid_idle", 32'(arvalid), 32'd0);
      check("s2_rready", 32'(rready), 32'd1);
      rvalid = 1'b1; rdata = 32'h1111_0001;
      tick();
      rvalid = 1'b0;
      settle();
      check("s2_reopen_addr_ok", 32'(inst_sram_addr_ok), 32'd1);
      check("s2_data_ok", 32'(inst_sram_data_ok), 32'd1);
      tick();
      inst_sram_req = 1'b0; inst_sram_wr = 1'b0;
      settle();
      check("s2_ar_reissue", 32'(arvalid), 32'd1);
      tick();
      arready = 1'b0;
      rvalid = 1'b1; rdata = 32'h1111_0002;
      tick();
      rdata = 32'h1111_0003;
      tick();
      rvalid = 1'b0;
      settle();
      check("s2_drained", 32'(rready), 32'd0);
      tick();

      // 3: AR backpressure for 5 cycles
      inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0200;
      settle();
      check("s3_addr_ok", 32'(inst_sram_addr_ok), 32'd1);
      tick();
      inst_sram_addr = 32'hDEAD_BEEF;
      for (int i = 0; i < 5; i++) begin
         settle();
         check("s3_arvalid_hold", 32'(arvalid), 32'd1);
         check("s3_araddr_hold", araddr, 32'h1C00_0200);
         check("s3_no_addr_ok", 32'(inst_sram_addr_ok), 32'd0);
         tick();
      end
      inst_sram_req = 1'b0;
      arready = 1'b1;
      tick();
      arready = 1'b0;
      settle();
      check("s3_single_hs", 32'(arvalid), 32'd0);
      check("s3_cnt_one", 32'(rready), 32'd1);

      // 4: accept and R handshake in the same cycle with cnt=1
      inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0300;
      rvalid = 1'b1; rdata = 32'h4444_0004;
      settle();
      check("s4_addr_ok", 32'(inst_sram_addr_ok), 32'd1);
      tick();
      inst_sram_req = 1'b0; rvalid = 1'b0;
      settle();
      check("s4_data_ok", 32'(inst_sram_data_ok), 32'd1);
      check("s4_cnt_held", 32'(rready), 32'd1);
      check("s4_araddr", araddr, 32'h1C00_0300);
      check("s4_arvalid", 32'(arvalid), 32'd1);
      arready = 1'b1;
      tick();
      arready = 1'b0;
      rvalid = 1'b1; rdata = 32'h5555_0005;
      tick();
      rvalid = 1'b0;
      settle();
      check("s4_drained", 32'(rready), 32'd0);
      tick();

      // 5: two reads, back-to-back in-order return
      arready = 1'b1;
      inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0000;
      tick();
      inst_sram_req = 1'b0;
      tick();
      inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0004;
      settle();
      check("s5_addr_ok2", 32'(inst_sram_addr_ok), 32'd1);
      tick();
      inst_sram_req = 1'b0;
      settle();
      check("s5_araddr2", araddr, 32'h1C00_0004);
      tick();
      arready = 1'b0;
      rvalid = 1'b1; rdata = 32'hAAAA_0001;
      tick();
      rdata = 32'hBBBB_0002;
      settle();
      check("s5_first_data_ok", 32'(inst_sram_data_ok), 32'd1);
      check("s5_first_rdata", inst_sram_rdata, 32'hAAAA_0001);
      tick();
      rvalid = 1'b0;
      settle();
      check("s5_second_data_ok", 32'(inst_sram_data_ok), 32'd1);
      check("s5_second_rdata", inst_sram_rdata, 32'hBBBB_0002);
      tick();
      check("s5_pulse_end", 32'(inst_sram_data_ok), 32'd0);
      check("s5_rdata_hold", inst_sram_rdata, 32'hBBBB_0002);

      // 6: reset while in AR_SEND with cnt=1
      inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0400;
      tick();
      inst_sram_req = 1'b0;
      settle();
      check("s6_pre_arvalid", 32'(arvalid), 32'd1);
      reset = 1'b1;
      tick();
      check("s6_arvalid", 32'(arvalid), 32'd0);
      check("s6_rready", 32'(rready), 32'd0);
      check("s6_data_ok", 32'(inst_sram_data_ok), 32'd0);
      reset = 1'b0;
      tick();
      single_fetch(32'h1C00_0000, 32'h0280_0404, "s6f");

      check("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/inst_axi_rd_bridge.md
Name: inst_axi_rd_bridge

Overview:
- Upstream neighbour of the fetch stage.
- Converts the fetch stage's SRAM-like instruction request interface (req/addr_ok/data_ok) into an AXI4 read-only master (AR and R channels).
- Tracks up to MAX_OUTSTANDING accepted requests in order. Returns exactly one data_ok per accepted address, with no reordering and no dropping.
- The AW/W/B channels are owned by the data-side bridge and are not part of this block.

Parameters:
- MAX_OUTSTANDING, 2, maximum accepted-but-unreturned reads (range 1..7).
- ARID_VAL, 4'h0, constant ID driven on arid.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- inst_sram_req  in  1  fetch request valid
- inst_sram_wr  in  1  write flag; ignored, every request is treated as a read
- inst_sram_size  in  2  log2 of byte count (2 = word)
- inst_sram_addr  in  32  fetch address
- inst_sram_addr_ok  out  1  address accepted this cycle
- inst_sram_data_ok  out  1  one-cycle pulse: rdata valid
- inst_sram_rdata  out  32  returned instruction
- arid  out  4  read ID, equals ARID_VAL
- araddr  out  32  read address
- arlen  out  8  burst length, constant 0
- arsize  out  3  {1'b0, latched size}
- arburst  out  2  burst type, constant 2'b01
- arlock  out  2  lock, constant 0
- arcache  out  4  cache attributes, constant 0
- arprot  out  3  protection, constant 0
- arvalid  out  1  AR channel valid
- arready  in  1  AR channel ready
- rid  in  4  read ID; ignored
- rdata  in  32  read data
- rresp  in  2  read response; ignored, no error path
- rlast  in  1  last beat; always 1 since arlen = 0, not checked
- rvalid  in  1  R channel valid
- rready  out  1  R channel ready

Behaviour:
- Reset values: arvalid=0, araddr=0, arsize=0, rready=0, inst_sram_data_ok=0, inst_sram_rdata=0, outstanding count cnt=0, AR FSM in AR_IDLE.
- cnt is $clog2(MAX_OUTSTANDING+1) bits wide.
- AR FSM, state AR_IDLE:
  - inst_sram_addr_ok = inst_sram_req & (cnt < MAX_OUTSTANDING). This is combinational in AR_IDLE only.
  - On addr_ok: latch addr into araddr and size into arsize, then go to AR_SEND.
- AR FSM, state AR_SEND:
  - arvalid=1 with araddr/arsize held stable; addr_ok=0.
  - On arvalid & arready: next cycle arvalid=0, return to AR_IDLE.
- Minimum address-to-address spacing is 2 cycles, which is acceptable.
- Counter:
  - cnt+1 on an addr_ok handshake; cnt-1 on an R handshake (rvalid & rready).
  - Both in the same cycle leaves cnt unchanged.
  - cnt never exceeds MAX_OUTSTANDING and never underflows.
- rready = (cnt != 0). An rvalid arriving with cnt==0 is not accepted.
- Return path, registered:
  - The cycle after an R handshake: inst_sram_data_ok=1 and inst_sram_rdata=captured rdata.
  - Otherwise data_ok=0 and rdata holds its last value.
  - Latency from R handshake to data_ok is exactly 1 cycle.
  - Back-to-back R beats produce back-to-back data_ok pulses.
- No backpressure on data_ok: the fetch stage always consumes it, and discards cancelled fetches itself. The bridge never cancels or drops an accepted request.
- Ordering: single ID, so the interconnect returns data in order, and data_ok order equals addr_ok order.
- Simultaneous events:
  - An addr_ok handshake and an R handshake in the same cycle are both honoured.
  - A request arriving while in AR_SEND is not acknowledged until AR_IDLE.
- Reset mid-operation: all state is cleared, including cnt and any pending AR.
  - The system resets the interconnect together with this block, so no stale R beats are expected.
- inst_sram_wr=1 behaves identically to a read; AW/W/B are never driven.

Decomposition:
- Shared package `axi_defs`:
  - AXI constants: BURST_INCR=2'b01, LEN_SINGLE=8'd0, CACHE_NONE, PROT_NONE, LOCK_NORMAL.
  - Fetch size encodings: SIZE_BYTE=0, SIZE_HALF=1, SIZE_WORD=2.
- AR FSM state typedef: AR_IDLE, AR_SEND.
- Single flat module; no sub-module needed. The counter and FSM are small enough to live inline.

Test Plan:
1. Single fetch:
   - Stimulus: req with addr=32'h1C00_0000, size=2; arready high the cycle arvalid rises; rvalid with rdata=32'h0280_0404 three cycles later.
   - Required: addr_ok for 1 cycle; araddr=32'h1C00_0000, arsize=3'b010, arlen=0; data_ok pulse 1 cycle after the R handshake with rdata=32'h0280_0404; cnt returns to 0.
2. Outstanding limit (MAX=2):
   - Stimulus: req held continuously; arready=1; rvalid held off.
   - Required: exactly 2 addr_ok pulses, then addr_ok stays 0 while cnt=2. After one R beat, the next addr_ok follows.
3. AR backpressure:
   - Stimulus: arready=0 for 5 cycles.
   - Required: arvalid and araddr held stable for all 5 cycles; no additional addr_ok; a single AR handshake when arready rises.
4. Simultaneous events:
   - Stimulus: with cnt=1, an addr_ok handshake and an R handshake land in the same cycle.
   - Required: cnt stays 1; data_ok next cycle; the new AR is issued normally.
5. In-order back-to-back return:
   - Stimulus: two reads to 0x1C000000 and 0x1C000004; R beats 0xAAAA_0001 then 0xBBBB_0002 on consecutive cycles.
   - Required: two consecutive data_ok pulses carrying the same values in the same order.
6. Reset mid-flight:
   - Stimulus: assert reset while in AR_SEND with cnt=1.
   - Required: next cycle arvalid=0, rready=0, cnt=0, data_ok=0. After reset deasserts, a fresh fetch completes as in scenario 1.
